// File: rtl/fft_pkg.sv
// Shared constants and helpers for the 8-point FFT / IDFT blocks.
package fft_pkg;

   localparam int          TW_Q15    = 23170;
   localparam int unsigned Q_SHIFT   = 15;
   localparam int unsigned N_PTS     = 8;
   localparam int unsigned GUARD_W   = 4;
   localparam int unsigned IN_W_DEF  = 32;
   localparam int unsigned OUT_W_DEF = 16;
   localparam int unsigned SAT_W     = 64;

   typedef struct packed {
      logic                    clip;
      logic signed [SAT_W-1:0] val;
   } sat_t;

   // Clamp x into the signed range of a w-bit word and report whether it clipped.
   function automatic sat_t sat_to_w(input logic signed [SAT_W-1:0] x, input int unsigned w);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      sat_t                    r;
      hi     = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo     = -(64'sd1 <<< (w - 1));
      r.clip = (x > hi) || (x < lo);
      r.val  = (x > hi) ? hi : ((x < lo) ? lo : x);
      return r;
   endfunction

endpackage

// File: rtl/fft_twiddle_mult.sv
// Complex multiply by c*(1+j) or c*(-1+j), c in Q1.15, result floored by the Q shift.
module fft_twiddle_mult
   import fft_pkg::*;
#(
   parameter int unsigned IW = 36,
   parameter int          C  = 23170
) (
   input  logic                 neg_re,
   input  logic signed [IW-1:0] a_re,
   input  logic signed [IW-1:0] a_im,
   output logic signed [IW-1:0] y_re,
   output logic signed [IW-1:0] y_im
);

   localparam int unsigned PW = IW + 18;
   localparam logic signed [PW-1:0] CW = PW'(C);

   logic signed [IW:0] diff;
   logic signed [IW:0] add;
   logic signed [IW:0] m_re;
   logic signed [IW:0] m_im;

   // c(1+j)(a+jb) = c(a-b) + jc(a+b);  c(-1+j)(a+jb) = -c(a+b) + jc(a-b)
   always_comb begin
      diff = (IW+1)'(a_re) - (IW+1)'(a_im);
      add  = (IW+1)'(a_re) + (IW+1)'(a_im);
      m_re = neg_re ? -add : diff;
      m_im = neg_re ? diff : add;
      y_re = IW'((PW'(m_re) * CW) >>> Q_SHIFT);
      y_im = IW'((PW'(m_im) * CW) >>> Q_SHIFT);
   end

endmodule

// File: rtl/fft_8point_idft.sv
// 8-point radix-2 DIT inverse DFT, 3-stage pipeline, output scaled by 1/8 and saturated.
module fft_8point_idft #(
   parameter int unsigned IN_W   = fft_pkg::IN_W_DEF,
   parameter int unsigned OUT_W  = fft_pkg::OUT_W_DEF,
   parameter int          TW_Q15 = fft_pkg::TW_Q15
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic                                     s_valid,
   output logic                                     s_ready,
   input  logic signed [fft_pkg::N_PTS-1:0][IN_W-1:0]  s_X_k_real,
   input  logic signed [fft_pkg::N_PTS-1:0][IN_W-1:0]  s_X_k_imag,
   output logic                                     m_valid,
   input  logic                                     m_ready,
   output logic signed [fft_pkg::N_PTS-1:0][OUT_W-1:0] m_x_n_real,
   output logic signed [fft_pkg::N_PTS-1:0][OUT_W-1:0] m_x_n_imag,
   output logic                                     m_sat
);
   import fft_pkg::*;

   localparam int unsigned IW = IN_W + GUARD_W;

   logic                 en;
   logic [2:0]           v_q;
   logic signed [IW-1:0] s1_re_d [N_PTS];
   logic signed [IW-1:0] s1_im_d [N_PTS];
   logic signed [IW-1:0] s1_re_q [N_PTS];
   logic signed [IW-1:0] s1_im_q [N_PTS];
   logic signed [IW-1:0] s2_re_d [N_PTS];
   logic signed [IW-1:0] s2_im_d [N_PTS];
   logic signed [IW-1:0] s2_re_q [N_PTS];
   logic signed [IW-1:0] s2_im_q [N_PTS];
   logic signed [IW-1:0] t_re [4];
   logic signed [IW-1:0] t_im [4];
   logic signed [IW-1:0] tw1_re, tw1_im, tw3_re, tw3_im;
   logic [OUT_W-1:0]     y_re_d [N_PTS];
   logic [OUT_W-1:0]     y_im_d [N_PTS];
   logic [OUT_W:0]       r_lo_re, r_lo_im, r_hi_re, r_hi_im;
   logic                 sat_d;

   assign en      = ~m_valid | m_ready;
   assign s_ready = en;
   assign m_valid = v_q[2];

   function automatic logic signed [IW-1:0] ext(input logic [IN_W-1:0] v);
      return IW'($signed(v));
   endfunction

   // Returns {clip, sample}: floor divide by 8, then saturate to OUT_W.
   function automatic logic [OUT_W:0] scale(input logic signed [IW-1:0] x);
      sat_t r;
      r = sat_to_w(SAT_W'(x >>> 3), OUT_W);
      return {r.clip, r.val[OUT_W-1:0]};
   endfunction

   // Stage 1 slots: 0/1=A, 2/3=B, 4/5=C, 6/7=D; A,B,C,D pair bins 0,2,1,3 with +4.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         s1_re_d[2*i]   = ext(s_X_k_real[2*(i%2)+i/2]) + ext(s_X_k_real[2*(i%2)+i/2+4]);
         s1_im_d[2*i]   = ext(s_X_k_imag[2*(i%2)+i/2]) + ext(s_X_k_imag[2*(i%2)+i/2+4]);
         s1_re_d[2*i+1] = ext(s_X_k_real[2*(i%2)+i/2]) - ext(s_X_k_real[2*(i%2)+i/2+4]);
         s1_im_d[2*i+1] = ext(s_X_k_imag[2*(i%2)+i/2]) - ext(s_X_k_imag[2*(i%2)+i/2+4]);
      end
   end

   // Stage 2 slots: 0..3 = E0..E3 from A,B; 4..7 = O0..O3 from C,D.
   always_comb begin
      for (int g = 0; g < 2; g++) begin
         s2_re_d[4*g]   = s1_re_q[4*g]   + s1_re_q[4*g+2];
         s2_im_d[4*g]   = s1_im_q[4*g]   + s1_im_q[4*g+2];
         s2_re_d[4*g+1] = s1_re_q[4*g+1] - s1_im_q[4*g+3];
         s2_im_d[4*g+1] = s1_im_q[4*g+1] + s1_re_q[4*g+3];
         s2_re_d[4*g+2] = s1_re_q[4*g]   - s1_re_q[4*g+2];
         s2_im_d[4*g+2] = s1_im_q[4*g]   - s1_im_q[4*g+2];
         s2_re_d[4*g+3] = s1_re_q[4*g+1] + s1_im_q[4*g+3];
         s2_im_d[4*g+3] = s1_im_q[4*g+1] - s1_re_q[4*g+3];
      end
   end

   fft_twiddle_mult #(.IW(IW), .C(TW_Q15)) u_tw1 (
      .neg_re (1'b0),
      .a_re   (s2_re_q[5]),
      .a_im   (s2_im_q[5]),
      .y_re   (tw1_re),
      .y_im   (tw1_im)
   );

   fft_twiddle_mult #(.IW(IW), .C(TW_Q15)) u_tw3 (
      .neg_re (1'b1),
      .a_re   (s2_re_q[7]),
      .a_im   (s2_im_q[7]),
      .y_re   (tw3_re),
      .y_im   (tw3_im)
   );

   always_comb begin
      t_re[0] = s2_re_q[4];
      t_im[0] = s2_im_q[4];
      t_re[1] = tw1_re;
      t_im[1] = tw1_im;
      t_re[2] = -s2_im_q[6];
      t_im[2] = s2_re_q[6];
      t_re[3] = tw3_re;
      t_im[3] = tw3_im;
      sat_d   = 1'b0;
      r_lo_re = '0;
      r_lo_im = '0;
      r_hi_re = '0;
      r_hi_im = '0;
      for (int k = 0; k < 4; k++) begin
         r_lo_re       = scale(s2_re_q[k] + t_re[k]);
         r_lo_im       = scale(s2_im_q[k] + t_im[k]);
         r_hi_re       = scale(s2_re_q[k] - t_re[k]);
         r_hi_im       = scale(s2_im_q[k] - t_im[k]);
         y_re_d[k]     = r_lo_re[OUT_W-1:0];
         y_im_d[k]     = r_lo_im[OUT_W-1:0];
         y_re_d[k+4]   = r_hi_re[OUT_W-1:0];
         y_im_d[k+4]   = r_hi_im[OUT_W-1:0];
         sat_d         = sat_d | r_lo_re[OUT_W] | r_lo_im[OUT_W] | r_hi_re[OUT_W] | r_hi_im[OUT_W];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v_q   <= '0;
         m_sat <= 1'b0;
         for (int k = 0; k < N_PTS; k++) begin
            s1_re_q[k]    <= '0;
            s1_im_q[k]    <= '0;
            s2_re_q[k]    <= '0;
            s2_im_q[k]    <= '0;
            m_x_n_real[k] <= '0;
            m_x_n_imag[k] <= '0;
         end
      end else if (en) begin
         v_q   <= {v_q[1:0], s_valid};
         m_sat <= sat_d;
         for (int k = 0; k < N_PTS; k++) begin
            s1_re_q[k]    <= s1_re_d[k];
            s1_im_q[k]    <= s1_im_d[k];
            s2_re_q[k]    <= s2_re_d[k];
            s2_im_q[k]    <= s2_im_d[k];
            m_x_n_real[k] <= y_re_d[k];
            m_x_n_imag[k] <= y_im_d[k];
         end
      end
   end

endmodule

// File: tb/tb_fft_8point_idft.sv
// Randomised and directed bench for fft_8point_idft against a direct 4+4 point IDFT model.
module tb_fft_8point_idft;

   localparam longint TW = 23170;

   typedef struct packed {
      logic [7:0][31:0] re;
      logic [7:0][31:0] im;
   } frame_t;

   typedef struct packed {
      logic [7:0][15:0] re;
      logic [7:0][15:0] im;
      logic             sat;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             s_valid = 1'b0;
   logic             s_ready;
   logic [7:0][31:0] s_X_k_real = '0;
   logic [7:0][31:0] s_X_k_imag = '0;
   logic             m_valid;
   logic             m_ready = 1'b1;
   logic [7:0][15:0] m_x_n_real;
   logic [7:0][15:0] m_x_n_imag;
   logic             m_sat;

   int     checks = 0;
   int     errors = 0;
   int     rx = 0;
   exp_t   q[$];
   bit     hold_v = 1'b0;
   logic [257:0] held;
   bit     rand_done = 1'b0;

   fft_8point_idft dut (
      .clk        (clk),
      .reset      (reset),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_X_k_real (s_X_k_real),
      .s_X_k_imag (s_X_k_imag),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_x_n_real (m_x_n_real),
      .m_x_n_imag (m_x_n_imag),
      .m_sat      (m_sat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Multiply (a + jb) by j^q.
   function automatic void rot(input longint a, input longint b, input int q,
                               output longint ra, output longint rb);
      case (q % 4)
         0:       begin ra = a;  rb = b;  end
         1:       begin ra = -b; rb = a;  end
         2:       begin ra = -a; rb = -b; end
         default: begin ra = b;  rb = -a; end
      endcase
   endfunction

   function automatic longint clamp16(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   // x[n] = E[n] + W^n O[n], x[n+4] = E[n] - W^n O[n], E/O = 4-point inverse DFTs of even/odd bins.
   function automatic exp_t model(input frame_t f);
      longint e_re[4], e_im[4], o_re[4], o_im[4], t_re[4], t_im[4];
      longint ar, ai, rr, ri, x, y, yc;
      exp_t   r;
      r = '0;
      for (int n = 0; n < 4; n++) begin
         e_re[n] = 0; e_im[n] = 0; o_re[n] = 0; o_im[n] = 0;
         for (int m = 0; m < 4; m++) begin
            ar = longint'($signed(f.re[2*m]));
            ai = longint'($signed(f.im[2*m]));
            rot(ar, ai, n * m, rr, ri);
            e_re[n] += rr; e_im[n] += ri;
            ar = longint'($signed(f.re[2*m+1]));
            ai = longint'($signed(f.im[2*m+1]));
            rot(ar, ai, n * m, rr, ri);
            o_re[n] += rr; o_im[n] += ri;
         end
      end
      for (int n = 0; n < 4; n++) begin
         if (n % 2 == 0) begin
            rot(o_re[n], o_im[n], n / 2, t_re[n], t_im[n]);
         end else begin
            rot(o_re[n], o_im[n], (n - 1) / 2, rr, ri);
            t_re[n] = (TW * (rr - ri)) >>> 15;
            t_im[n] = (TW * (rr + ri)) >>> 15;
         end
      end
      for (int k = 0; k < 8; k++) begin
         x  = (k < 4) ? e_re[k%4] + t_re[k%4] : e_re[k%4] - t_re[k%4];
         y  = x >>> 3;
         yc = clamp16(y);
         r.re[k] = 16'(yc);
         if (yc != y) r.sat = 1'b1;
         x  = (k < 4) ? e_im[k%4] + t_im[k%4] : e_im[k%4] - t_im[k%4];
         y  = x >>> 3;
         yc = clamp16(y);
         r.im[k] = 16'(yc);
         if (yc != y) r.sat = 1'b1;
      end
      return r;
   endfunction

   function automatic frame_t rand_frame();
      frame_t f;
      int     mode;
      mode = $urandom_range(0, 3);
      for (int k = 0; k < 8; k++) begin
         case (mode)
            0: begin
               f.re[k] = $urandom;
               f.im[k] = $urandom;
            end
            1: begin
               f.re[k] = 32'($urandom_range(0, 4000)) - 32'd2000;
               f.im[k] = 32'($urandom_range(0, 4000)) - 32'd2000;
            end
            default: begin
               f.re[k] = 32'($urandom_range(0, 131072)) - 32'd65536;
               f.im[k] = 32'($urandom_range(0, 131072)) - 32'd65536;
            end
         endcase
      end
      return f;
   endfunction

   // Scoreboard: on each negedge check held outputs, pop on emit, push model on accept.
   always @(negedge clk) begin
      exp_t   e;
      frame_t fr;
      if (reset) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            checks++;
            if ({m_valid, m_sat, m_x_n_real, m_x_n_imag} !== held) begin
               errors++;
               $display("FAIL hold_stable: got %h expected %h",
                        {m_valid, m_sat, m_x_n_real, m_x_n_imag}, held);
            end
         end
         if (m_valid && m_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame: got m_valid=1 expected no frame pending");
            end else begin
               e = q.pop_front();
               rx++;
               for (int k = 0; k < 8; k++) begin
                  chk($sformatf("x%0d_re", k), $signed(m_x_n_real[k]), $signed(e.re[k]));
                  chk($sformatf("x%0d_im", k), $signed(m_x_n_imag[k]), $signed(e.im[k]));
               end
               chk("frame_sat", m_sat, e.sat);
            end
         end
         if (s_valid && s_ready) begin
            fr.re = s_X_k_real;
            fr.im = s_X_k_imag;
            q.push_back(model(fr));
         end
         hold_v = m_valid && !m_ready;
         held   = {m_valid, m_sat, m_x_n_real, m_x_n_imag};
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called 1 time unit after a rising edge; returns 1 time unit after the accepting edge.
   task automatic send(input frame_t f);
      int budget;
      budget     = 0;
      s_X_k_real = f.re;
      s_X_k_imag = f.im;
      s_valid    = 1'b1;
      @(negedge clk);
      while (!s_ready && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      if (!s_ready) chk("send_accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   // Edges from the accepting edge (counted as 1) until m_valid is seen.
   task automatic wait_out(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!m_valid && lat < 20);
   endtask

   task automatic drain(input string name);
      int budget;
      budget = 0;
      while ((q.size() != 0 || m_valid) && budget < 60) begin
         @(negedge clk);
         budget++;
      end
      chk(name, q.size(), 0);
   endtask

   initial begin
      frame_t f;
      int     lat;
      int     rx0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_sat", m_sat, 0);
      chk("rst_x0_re", m_x_n_real[0], 0);
      chk("rst_x7_im", m_x_n_imag[7], 0);
      chk("rst_s_ready", s_ready, 1);
      step();
      reset = 1'b0;

      // DC bin
      f = '0;
      f.re[0] = 32'd800;
      send(f);
      wait_out(lat);
      chk("dc_latency", lat, 3);
      chk("dc_x0_re", $signed(m_x_n_real[0]), 100);
      chk("dc_x5_re", $signed(m_x_n_real[5]), 100);
      chk("dc_x3_im", $signed(m_x_n_imag[3]), 0);
      chk("dc_sat", m_sat, 0);

      // Single tone in bin 1
      step();
      f = '0;
      f.re[1] = 32'd8;
      send(f);
      wait_out(lat);
      chk("tone_latency", lat, 3);
      chk("tone_x0_re", $signed(m_x_n_real[0]), 1);
      chk("tone_x0_im", $signed(m_x_n_imag[0]), 0);
      chk("tone_x2_re", $signed(m_x_n_real[2]), 0);
      chk("tone_x2_im", $signed(m_x_n_imag[2]), 1);
      chk("tone_x3_re", $signed(m_x_n_real[3]), -1);
      chk("tone_x6_im", $signed(m_x_n_imag[6]), -1);

      // Round trip of forward FFT of an impulse
      step();
      for (int k = 0; k < 8; k++) begin
         f.re[k] = 32'd8;
         f.im[k] = 32'd0;
      end
      send(f);
      wait_out(lat);
      chk("rt_x0_re", $signed(m_x_n_real[0]), 8);
      chk("rt_x1_re", $signed(m_x_n_real[1]), 0);
      chk("rt_x4_re", $signed(m_x_n_real[4]), 0);
      chk("rt_x0_im", $signed(m_x_n_imag[0]), 0);

      // Saturation, then a clean frame
      step();
      f = '0;
      f.re[0] = 32'h7FFF_FFFF;
      send(f);
      wait_out(lat);
      chk("sat_x0_re", $signed(m_x_n_real[0]), 32767);
      chk("sat_x7_re", $signed(m_x_n_real[7]), 32767);
      chk("sat_flag", m_sat, 1);
      step();
      f = '0;
      send(f);
      wait_out(lat);
      chk("sat_clear_flag", m_sat, 0);
      chk("sat_clear_x0_re", $signed(m_x_n_real[0]), 0);

      // Backpressure: 4 back-to-back frames with a 5-clock stall
      step();
      rx0 = rx;
      fork
         begin
            for (int i = 0; i < 4; i++) send(rand_frame());
         end
         begin
            repeat (2) @(posedge clk);
            #1;
            m_ready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               if (m_valid) chk("stall_s_ready", s_ready, 0);
            end
            @(posedge clk);
            #1;
            m_ready = 1'b1;
         end
      join
      drain("bp_drain");
      chk("bp_frame_count", rx - rx0, 4);

      // Random traffic with random backpressure
      step();
      rand_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 60; i++) begin
               repeat ($urandom_range(0, 2)) step();
               send(rand_frame());
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               step();
               m_ready = ($urandom_range(0, 3) != 0);
            end
            m_ready = 1'b1;
         end
      join
      drain("rand_drain");

      // Asynchronous reset with two frames in flight
      step();
      m_ready = 1'b1;
      f = '0;
      f.re[1] = 32'd8;
      send(f);
      send(rand_frame());
      @(posedge clk);
      #2;
      reset = 1'b1;
      q.delete();
      #1;
      chk("arst_m_valid", m_valid, 0);
      chk("arst_x0_re", m_x_n_real[0], 0);
      chk("arst_m_sat", m_sat, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      f = '0;
      f.re[0] = 32'd800;
      send(f);
      wait_out(lat);
      chk("arst_new_latency", lat, 3);
      chk("arst_new_x0_re", $signed(m_x_n_real[0]), 100);
      repeat (6) @(negedge clk);
      chk("arst_no_stale", m_valid, 0);
      drain("arst_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
